// File: rtl/fifo_flags.sv
// fifo_flags: synchronous FIFO with show-ahead/registered read, programmable thresholds and sticky error flags
// Ports:
//   i_clk, i_reset_n_w          clock, asynchronous active-low reset
//   i_clear_w                   synchronous flush (pointers and sticky flags to zero)
//   i_data_w, i_write_w         write data and request
//   i_read_w                    read request (advances the head)
//   o_data_w, o_valid_w         read data; valid pulse (registered mode) or !empty (show-ahead)
//   i_afull_lvl_w, i_aempty_lvl_w  live almost-full / almost-empty thresholds
//   o_full_w, o_empty_w, o_afull_w, o_aempty_w  status flags from registered pointers
//   o_overflow_w, o_underflow_w sticky rejected-write / rejected-read flags
//   o_fill_bytes_w              current entry count
module fifo_flags #(
    parameter int FIFO_WIDTH = 8,
    parameter int FIFO_DEPTH = 4,
    parameter bit SHOW_AHEAD = 1
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n_w,
    input  logic                  i_clear_w,
    input  logic [FIFO_WIDTH-1:0] i_data_w,
    input  logic                  i_write_w,
    input  logic                  i_read_w,
    output logic [FIFO_WIDTH-1:0] o_data_w,
    output logic                  o_valid_w,
    input  logic [FIFO_DEPTH:0]   i_afull_lvl_w,
    input  logic [FIFO_DEPTH:0]   i_aempty_lvl_w,
    output logic                  o_full_w,
    output logic                  o_empty_w,
    output logic                  o_afull_w,
    output logic                  o_aempty_w,
    output logic                  o_overflow_w,
    output logic                  o_underflow_w,
    output logic [FIFO_DEPTH:0]   o_fill_bytes_w
);
    localparam int CAP = 1 << FIFO_DEPTH;
    logic [FIFO_WIDTH-1:0] mem [CAP];
    logic [FIFO_DEPTH:0]   wr_ptr, rd_ptr;
    logic                  rd_ok, wr_ok;
    assign o_fill_bytes_w = wr_ptr - rd_ptr;
    assign o_empty_w      = wr_ptr == rd_ptr;
    // full: same slot, opposite wrap bit
    assign o_full_w       = (wr_ptr ^ rd_ptr) == {1'b1, {FIFO_DEPTH{1'b0}}};
    assign o_afull_w      = o_fill_bytes_w >= i_afull_lvl_w;
    assign o_aempty_w     = o_fill_bytes_w <= i_aempty_lvl_w;
    // a read frees a slot in the same edge, so a full FIFO still takes a write alongside it
    assign rd_ok = i_read_w && !o_empty_w && !i_clear_w;
    assign wr_ok = i_write_w && (!o_full_w || rd_ok) && !i_clear_w;
    always_ff @(posedge i_clk or negedge i_reset_n_w) begin
        if (!i_reset_n_w) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            o_overflow_w  <= 1'b0;
            o_underflow_w <= 1'b0;
        end else if (i_clear_w) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            o_overflow_w  <= 1'b0;
            o_underflow_w <= 1'b0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
            if (i_write_w && !wr_ok) o_overflow_w <= 1'b1;
            if (i_read_w && !rd_ok) o_underflow_w <= 1'b1;
        end
    end
    always_ff @(posedge i_clk) begin
        if (wr_ok) mem[wr_ptr[FIFO_DEPTH-1:0]] <= i_data_w;
    end
    if (SHOW_AHEAD) begin : g_show_ahead
        assign o_data_w  = mem[rd_ptr[FIFO_DEPTH-1:0]];
        assign o_valid_w = !o_empty_w;
    end else begin : g_registered
        logic [FIFO_WIDTH-1:0] rdata;
        logic                  rvalid;
        always_ff @(posedge i_clk or negedge i_reset_n_w) begin
            if (!i_reset_n_w) begin
                rdata  <= '0;
                rvalid <= 1'b0;
            end else begin
                rvalid <= rd_ok;
                if (rd_ok) rdata <= mem[rd_ptr[FIFO_DEPTH-1:0]];
            end
        end
        assign o_data_w  = rdata;
        assign o_valid_w = rvalid;
    end
endmodule

// File: tb/tb_fifo_flags.sv
// tb_fifo_flags: randomized and directed checks of both read modes against a queue model
module tb_fifo_flags;
    logic       clk = 1'b0;
    logic       rst_n, clr, wr, rd;
    logic [7:0] din;
    logic [4:0] afl, ael;
    logic [7:0] d1, d0;
    logic       v1, f1, e1, af1, ae1, ov1, un1;
    logic       v0, f0, e0, af0, ae0, ov0, un0;
    logic [4:0] fb1, fb0;
    int         n_cmp = 0, n_err = 0;
    logic [7:0] q[$];
    logic       m_ov, m_un, m_v0;
    logic [7:0] m_d0;

    always #5 clk = ~clk;

    fifo_flags #(.FIFO_WIDTH(8), .FIFO_DEPTH(4), .SHOW_AHEAD(1)) u_sa1 (
        .i_clk(clk), .i_reset_n_w(rst_n), .i_clear_w(clr), .i_data_w(din),
        .i_write_w(wr), .i_read_w(rd), .o_data_w(d1), .o_valid_w(v1),
        .i_afull_lvl_w(afl), .i_aempty_lvl_w(ael), .o_full_w(f1), .o_empty_w(e1),
        .o_afull_w(af1), .o_aempty_w(ae1), .o_overflow_w(ov1), .o_underflow_w(un1),
        .o_fill_bytes_w(fb1));

    fifo_flags #(.FIFO_WIDTH(8), .FIFO_DEPTH(4), .SHOW_AHEAD(0)) u_sa0 (
        .i_clk(clk), .i_reset_n_w(rst_n), .i_clear_w(clr), .i_data_w(din),
        .i_write_w(wr), .i_read_w(rd), .o_data_w(d0), .o_valid_w(v0),
        .i_afull_lvl_w(afl), .i_aempty_lvl_w(ael), .o_full_w(f0), .o_empty_w(e0),
        .o_afull_w(af0), .o_aempty_w(ae0), .o_overflow_w(ov0), .o_underflow_w(un0),
        .o_fill_bytes_w(fb0));

    task automatic model_reset();
        q.delete();
        m_ov = 1'b0;
        m_un = 1'b0;
        m_v0 = 1'b0;
        m_d0 = 8'h00;
    endtask

    // one clock: drive, take the edge, then advance the queue model
    task automatic step(input logic w, input logic [7:0] d, input logic r, input logic c);
        int   cnt;
        logic ra, wa;
        wr = w; din = d; rd = r; clr = c;
        cnt = q.size();
        ra = r && !c && cnt > 0;
        wa = w && !c && (cnt < 16 || ra);
        @(posedge clk); #1;
        if (c) begin
            q.delete();
            m_ov = 1'b0;
            m_un = 1'b0;
            m_v0 = 1'b0;
        end else begin
            m_v0 = ra;
            if (ra) m_d0 = q.pop_front();
            if (wa) q.push_back(d);
            if (w && !wa) m_ov = 1'b1;
            if (r && !ra) m_un = 1'b1;
        end
        wr = 1'b0; rd = 1'b0; clr = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clr = 0; wr = 0; rd = 0; din = 0; afl = 5'd12; ael = 5'd0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_cmp += 9;
        if (e1 !== 1'b1 || e0 !== 1'b1) begin n_err++; $display("FAIL reset_empty: got %b/%b want 1", e1, e0); end
        if (f1 !== 1'b0) begin n_err++; $display("FAIL reset_full: got %b want 0", f1); end
        if (fb1 !== 5'd0) begin n_err++; $display("FAIL reset_fill: got %0d want 0", fb1); end
        if (ae1 !== 1'b1) begin n_err++; $display("FAIL reset_aempty: got %b want 1", ae1); end
        if (af1 !== 1'b0) begin n_err++; $display("FAIL reset_afull12: got %b want 0", af1); end
        if (ov1 !== 1'b0 || un1 !== 1'b0) begin n_err++; $display("FAIL reset_sticky: got %b%b want 00", ov1, un1); end
        if (d0 !== 8'h00) begin n_err++; $display("FAIL reset_data0: got %h want 00", d0); end
        if (v0 !== 1'b0 || v1 !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b/%b want 0", v0, v1); end
        afl = 5'd0; #1;
        if (af1 !== 1'b1) begin n_err++; $display("FAIL reset_afull0: got %b want 1", af1); end
        rst_n = 1'b1;
        afl = 5'd12; ael = 5'd3;
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 16; i++) step(1, 8'(i), 0, 0);
        n_cmp += 4;
        if (f1 !== 1'b1) begin n_err++; $display("FAIL fill_full: got %b want 1", f1); end
        if (fb1 !== 5'd16) begin n_err++; $display("FAIL fill_count: got %0d want 16", fb1); end
        step(1, 8'hAA, 0, 0);
        if (ov1 !== 1'b1 || ov0 !== 1'b1) begin n_err++; $display("FAIL overflow_set: got %b/%b want 1", ov1, ov0); end
        if (fb1 !== 5'd16) begin n_err++; $display("FAIL overflow_count: got %0d want 16", fb1); end
    endtask

    task automatic test_drain_wrap();
        for (int i = 1; i <= 16; i++) begin
            n_cmp += 2;
            if (d1 !== 8'(i)) begin n_err++; $display("FAIL drain_sa1[%0d]: got %h want %h", i, d1, 8'(i)); end
            step(0, 0, 1, 0);
            if (d0 !== 8'(i) || v0 !== 1'b1) begin n_err++; $display("FAIL drain_sa0[%0d]: got %h/%b want %h/1", i, d0, v0, 8'(i)); end
        end
        n_cmp += 2;
        if (e1 !== 1'b1) begin n_err++; $display("FAIL drain_empty: got %b want 1", e1); end
        step(0, 0, 1, 0);
        if (un1 !== 1'b1 || un0 !== 1'b1) begin n_err++; $display("FAIL underflow_set: got %b/%b want 1", un1, un0); end
        for (int i = 0; i < 16; i++) step(1, 8'(8'h20 + i), 0, 0);
        for (int i = 0; i < 16; i++) begin
            n_cmp++;
            if (d1 !== 8'(8'h20 + i)) begin n_err++; $display("FAIL wrap_sa1[%0d]: got %h want %h", i, d1, 8'(8'h20 + i)); end
            step(0, 0, 1, 0);
            n_cmp++;
            if (d0 !== 8'(8'h20 + i)) begin n_err++; $display("FAIL wrap_sa0[%0d]: got %h want %h", i, d0, 8'(8'h20 + i)); end
        end
    endtask

    task automatic test_simultaneous();
        step(0, 0, 0, 1);
        for (int i = 0; i < 16; i++) step(1, 8'(8'h40 + i), 0, 0);
        step(1, 8'h55, 1, 0);
        n_cmp += 2;
        if (fb1 !== 5'd16) begin n_err++; $display("FAIL full_rw_count: got %0d want 16", fb1); end
        if (ov1 !== 1'b0) begin n_err++; $display("FAIL full_rw_overflow: got %b want 0", ov1); end
        for (int i = 0; i < 16; i++) step(0, 0, 1, 0);
        n_cmp++;
        if (d0 !== 8'h55) begin n_err++; $display("FAIL full_rw_last: got %h want 55", d0); end
        step(1, 8'h66, 1, 0);
        n_cmp += 3;
        if (fb1 !== 5'd1) begin n_err++; $display("FAIL empty_rw_count: got %0d want 1", fb1); end
        if (un1 !== 1'b1) begin n_err++; $display("FAIL empty_rw_underflow: got %b want 1", un1); end
        if (d1 !== 8'h66) begin n_err++; $display("FAIL empty_rw_head: got %h want 66", d1); end
        step(0, 0, 1, 0);
        n_cmp++;
        if (d0 !== 8'h66) begin n_err++; $display("FAIL empty_rw_read: got %h want 66", d0); end
    endtask

    task automatic test_thresholds();
        step(0, 0, 0, 1);
        afl = 5'd12; ael = 5'd3;
        for (int i = 0; i < 3; i++) step(1, 8'(i), 0, 0);
        n_cmp += 5;
        if (ae1 !== 1'b1) begin n_err++; $display("FAIL aempty_at3: got %b want 1", ae1); end
        step(1, 8'h03, 0, 0);
        if (ae1 !== 1'b0) begin n_err++; $display("FAIL aempty_at4: got %b want 0", ae1); end
        for (int i = 0; i < 7; i++) step(1, 8'(i), 0, 0);
        if (af1 !== 1'b0) begin n_err++; $display("FAIL afull_at11: got %b want 0", af1); end
        step(1, 8'h0B, 0, 0);
        if (af1 !== 1'b1) begin n_err++; $display("FAIL afull_at12: got %b want 1", af1); end
        afl = 5'd13; #1;
        if (af1 !== 1'b0) begin n_err++; $display("FAIL afull_live13: got %b want 0", af1); end
        afl = 5'd12;
    endtask

    task automatic test_registered_read();
        step(0, 0, 0, 1);
        step(1, 8'h3C, 0, 0);
        step(1, 8'h3D, 0, 0);
        n_cmp += 4;
        if (v0 !== 1'b0) begin n_err++; $display("FAIL sa0_idle_valid: got %b want 0", v0); end
        step(0, 0, 1, 0);
        if (d0 !== 8'h3C || v0 !== 1'b1) begin n_err++; $display("FAIL sa0_read1: got %h/%b want 3c/1", d0, v0); end
        step(0, 0, 1, 0);
        if (d0 !== 8'h3D || v0 !== 1'b1) begin n_err++; $display("FAIL sa0_read2: got %h/%b want 3d/1", d0, v0); end
        step(0, 0, 0, 0);
        if (d0 !== 8'h3D || v0 !== 1'b0) begin n_err++; $display("FAIL sa0_hold: got %h/%b want 3d/0", d0, v0); end
    endtask

    task automatic test_clear();
        step(0, 0, 0, 1);
        for (int i = 0; i < 17; i++) step(1, 8'(8'h70 + i), 0, 0);
        for (int i = 0; i < 11; i++) step(0, 0, 1, 0);
        n_cmp += 4;
        if (fb1 !== 5'd5 || ov1 !== 1'b1) begin n_err++; $display("FAIL clear_setup: got %0d/%b want 5/1", fb1, ov1); end
        step(1, 8'h77, 1, 1);
        if (fb1 !== 5'd0 || e1 !== 1'b1) begin n_err++; $display("FAIL clear_count: got %0d/%b want 0/1", fb1, e1); end
        if (ov1 !== 1'b0 || un1 !== 1'b0) begin n_err++; $display("FAIL clear_sticky: got %b%b want 00", ov1, un1); end
        if (v0 !== 1'b0 || d0 !== m_d0) begin n_err++; $display("FAIL clear_sa0: got %h/%b want %h/0", d0, v0, m_d0); end
    endtask

    task automatic test_random();
        step(0, 0, 0, 1);
        for (int i = 0; i < 600; i++) begin
            afl = 5'($urandom_range(0, 31));
            ael = 5'($urandom_range(0, 31));
            step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 49) == 0);
            n_cmp += 8;
            if (fb1 !== 5'(q.size()) || fb0 !== 5'(q.size())) begin n_err++; $display("FAIL rnd_count[%0d]: got %0d/%0d want %0d", i, fb1, fb0, q.size()); end
            if (e1 !== (q.size() == 0) || f1 !== (q.size() == 16)) begin n_err++; $display("FAIL rnd_empty_full[%0d]: got %b%b want %b%b", i, e1, f1, q.size() == 0, q.size() == 16); end
            if (af1 !== (q.size() >= int'(afl)) || ae1 !== (q.size() <= int'(ael))) begin n_err++; $display("FAIL rnd_thresh[%0d]: got %b%b", i, af1, ae1); end
            if (ov1 !== m_ov || ov0 !== m_ov) begin n_err++; $display("FAIL rnd_overflow[%0d]: got %b want %b", i, ov1, m_ov); end
            if (un1 !== m_un || un0 !== m_un) begin n_err++; $display("FAIL rnd_underflow[%0d]: got %b want %b", i, un1, m_un); end
            if (v1 !== (q.size() != 0)) begin n_err++; $display("FAIL rnd_valid1[%0d]: got %b", i, v1); end
            if (q.size() != 0 && d1 !== q[0]) begin n_err++; $display("FAIL rnd_head[%0d]: got %h want %h", i, d1, q[0]); end
            if (v0 !== m_v0 || d0 !== m_d0) begin n_err++; $display("FAIL rnd_sa0[%0d]: got %h/%b want %h/%b", i, d0, v0, m_d0, m_v0); end
        end
    endtask

    task automatic test_async_reset();
        step(0, 0, 0, 1);
        for (int i = 0; i < 6; i++) step(1, 8'(i), 0, 0);
        wr = 1'b1; din = 8'hEE;
        #3 rst_n = 1'b0;
        #1;
        n_cmp += 2;
        if (e1 !== 1'b1 || e0 !== 1'b1) begin n_err++; $display("FAIL async_empty: got %b/%b want 1", e1, e0); end
        if (fb1 !== 5'd0) begin n_err++; $display("FAIL async_count: got %0d want 0", fb1); end
        wr = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b1;
        model_reset();
        step(0, 0, 0, 0);
        n_cmp++;
        if (e1 !== 1'b1 || fb1 !== 5'd0) begin n_err++; $display("FAIL async_after: got %b/%0d want 1/0", e1, fb1); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain_wrap();
        test_simultaneous();
        test_thresholds();
        test_registered_read();
        test_clear();
        test_random();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
